// File: rtl/stack_seq.sv
// stack_seq: push/pop/peek sequencer for the stack pointer, stack memory and bus.
// Optional STACK_SEQ_AFULL_EN adds a registered almost-full output o_afull.
module stack_seq #(
  parameter int DEPTH        = 256,
  parameter int DEPTH_W      = 16,
  parameter int AFULL_MARGIN = 4
) (
  input  logic               i_clock,
  input  logic               i_reset_n,
  input  logic               i_req,
  input  logic [1:0]         i_op,
  input  logic [15:0]        i_data,
  output logic               o_ready,
  output logic               o_done,
  output logic               o_err,
  output logic [15:0]        o_data,
  output logic [DEPTH_W-1:0] o_depth,
  output logic               o_full,
  output logic               o_empty,
  output logic [2:0]         o_sp_ctrl,
  output logic               o_mem_w,
  output logic               o_mem_s,
  output logic               o_bus_en,
  output logic [15:0]        o_bus_data,
`ifdef STACK_SEQ_AFULL_EN
  output logic               o_afull,
`endif
  input  logic [15:0]        i_bus
);

  if (DEPTH < 1 || DEPTH > 65535 || AFULL_MARGIN < 0) begin : g_bad_cfg
    $error("stack_seq: bad DEPTH/AFULL_MARGIN");
  end
  if ((64'd1 << DEPTH_W) <= 64'(DEPTH)) begin : g_bad_w
    $error("stack_seq: DEPTH_W too narrow");
  end

  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_PUSH = 2'b01;
  localparam logic [1:0] OP_POP  = 2'b10;
  localparam logic [1:0] OP_PEEK = 2'b11;

  localparam logic [2:0] SP_HOLD = 3'b000;
  localparam logic [2:0] SP_INC  = 3'b001;
  localparam logic [2:0] SP_DEC  = 3'b010;

  typedef enum logic [3:0] {
    IDLE, PUSH_WR, PUSH_INC, POP_DEC, POP_RD,
    PK_DEC, PK_RD, PK_INC, ERR, DONE
  } state_t;

  state_t             state, nxt;
  logic [DEPTH_W-1:0] depth, depth_nxt;
  logic               accept;

  assign o_depth = depth;
  assign o_full  = (depth == DEPTH_W'(DEPTH));
  assign o_empty = (depth == '0);
  assign accept  = (state == IDLE) && i_req && (i_op != OP_NOP);

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: begin
        if (accept) begin
          unique case (1'b1)
            i_op == OP_PUSH: nxt = o_full  ? ERR : PUSH_WR;
            i_op == OP_POP:  nxt = o_empty ? ERR : POP_DEC;
            i_op == OP_PEEK: nxt = o_empty ? ERR : PK_DEC;
          endcase
        end
      end
      PUSH_WR:  nxt = PUSH_INC;
      PUSH_INC: nxt = DONE;
      POP_DEC:  nxt = POP_RD;
      POP_RD:   nxt = DONE;
      PK_DEC:   nxt = PK_RD;
      PK_RD:    nxt = PK_INC;
      PK_INC:   nxt = DONE;
      ERR:      nxt = IDLE;
      DONE:     nxt = IDLE;
      default:  nxt = IDLE;
    endcase
  end

  always_comb begin
    depth_nxt = depth;
    if (state == PUSH_INC) depth_nxt = depth + 1'b1;
    if (state == POP_RD)   depth_nxt = depth - 1'b1;
  end

  // Strobes are decoded from the next state so they line up with the state itself.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state      <= IDLE;
      depth      <= '0;
      o_ready    <= 1'b1;
      o_done     <= 1'b0;
      o_err      <= 1'b0;
      o_data     <= '0;
      o_sp_ctrl  <= SP_HOLD;
      o_mem_w    <= 1'b0;
      o_mem_s    <= 1'b1;
      o_bus_en   <= 1'b0;
      o_bus_data <= '0;
`ifdef STACK_SEQ_AFULL_EN
      o_afull    <= 1'b0;
`endif
    end else begin
      state     <= nxt;
      depth     <= depth_nxt;
      o_ready   <= (nxt == IDLE);
      o_done    <= (nxt == DONE) || (nxt == ERR);
      o_err     <= (nxt == ERR);
      o_bus_en  <= (nxt == PUSH_WR);
      o_mem_w   <= (nxt == PUSH_WR);
      o_mem_s   <= !((nxt == POP_RD) || (nxt == PK_RD));
      o_sp_ctrl <= SP_HOLD;
      if (nxt == PUSH_INC || nxt == PK_INC) o_sp_ctrl <= SP_INC;
      if (nxt == POP_DEC || nxt == PK_DEC)  o_sp_ctrl <= SP_DEC;
      if (accept && i_op == OP_PUSH) o_bus_data <= i_data;
      if (state == POP_RD || state == PK_RD) o_data <= i_bus;
`ifdef STACK_SEQ_AFULL_EN
      o_afull <= (int'(depth_nxt) >= DEPTH - AFULL_MARGIN);
`endif
    end
  end

endmodule

// File: tb/tb_stack_seq.sv
// tb_stack_seq: directed bench for stack_seq with a small stack memory/SP model.
// Build with STACK_SEQ_AFULL_EN to also cover o_afull (DEPTH=8, margin 2).
module tb_stack_seq;
`ifdef STACK_SEQ_AFULL_EN
  localparam int D  = 8;
  localparam int DW = 4;
  localparam int M  = 2;
`else
  localparam int D  = 4;
  localparam int DW = 3;
  localparam int M  = 4;
`endif
  localparam logic [1:0] PUSH = 2'b01;
  localparam logic [1:0] POP  = 2'b10;
  localparam logic [1:0] PEEK = 2'b11;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req = 1'b0;
  logic [1:0]    opr = 2'b00;
  logic [15:0]   din = '0;
  logic          ready, done, err, full, empty, mem_w, mem_s, bus_en;
  logic [15:0]   dout, bus_data, bus;
  logic [DW-1:0] depth;
  logic [2:0]    sp_ctrl;
`ifdef STACK_SEQ_AFULL_EN
  logic          afull;
`endif

  int checks = 0;
  int failures = 0;
  bit conflict = 1'b0;

  logic [15:0] mem [0:255];
  logic [7:0]  sp = 8'd20;

  always #5 clk = ~clk;

  stack_seq #(.DEPTH(D), .DEPTH_W(DW), .AFULL_MARGIN(M)) dut (
    .i_clock(clk), .i_reset_n(rst_n), .i_req(req), .i_op(opr),
    .i_data(din), .o_ready(ready), .o_done(done), .o_err(err),
    .o_data(dout), .o_depth(depth), .o_full(full), .o_empty(empty),
    .o_sp_ctrl(sp_ctrl), .o_mem_w(mem_w), .o_mem_s(mem_s),
    .o_bus_en(bus_en), .o_bus_data(bus_data),
`ifdef STACK_SEQ_AFULL_EN
    .o_afull(afull),
`endif
    .i_bus(bus)
  );

  assign bus = !mem_s ? mem[sp] : (bus_en ? bus_data : 16'h0);

  always @(posedge clk) begin
    if (mem_w) mem[sp] <= bus_data;
    if (sp_ctrl == 3'b001) sp <= sp + 8'd1;
    if (sp_ctrl == 3'b010) sp <= sp - 8'd1;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic run_op(input logic [1:0] op, input logic [15:0] d,
                        input bit hold, output int lat, output logic e,
                        output int nw, output int ninc, output int ndec,
                        output int nrdy);
    lat = 0; e = 1'b0; nw = 0; ninc = 0; ndec = 0; nrdy = 0;
    @(negedge clk);
    req = 1'b1; opr = op; din = d;
    @(posedge clk);
    for (int k = 1; k <= 12 && lat == 0; k++) begin
      @(negedge clk);
      if (!hold) req = 1'b0;
      if (mem_w && bus_en) nw++;
      if (sp_ctrl == 3'b001) ninc++;
      if (sp_ctrl == 3'b010) ndec++;
      if (ready) nrdy++;
      if (bus_en && !mem_s) conflict = 1'b1;
      if (done) begin
        lat = k;
        e = err;
      end
    end
    req = 1'b0;
  endtask

  task automatic op_chk(input string tag, input logic [1:0] op,
                        input logic [15:0] d, input int xlat,
                        input logic xerr, input int xw, input int xi,
                        input int xd);
    int lat, nw, ni, nd, nr;
    logic e;
    run_op(op, d, 1'b0, lat, e, nw, ni, nd, nr);
    chk({tag, "_lat"}, lat, xlat);
    chk({tag, "_err"}, {31'b0, e}, {31'b0, xerr});
    chk({tag, "_wr"}, nw, xw);
    chk({tag, "_inc"}, ni, xi);
    chk({tag, "_dec"}, nd, xd);
    chk({tag, "_rdy"}, nr, 0);
  endtask

  initial begin
    logic [7:0] sp0;
    int lat, nw, ni, nd, nr;
    logic e;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", {31'b0, ready}, 1);
    chk("rst_done", {31'b0, done}, 0);
    chk("rst_err", {31'b0, err}, 0);
    chk("rst_data", {16'b0, dout}, 0);
    chk("rst_depth", 32'(depth), 0);
    chk("rst_empty", {31'b0, empty}, 1);
    chk("rst_full", {31'b0, full}, 0);
    chk("rst_spc", {29'b0, sp_ctrl}, 0);
    chk("rst_memw", {31'b0, mem_w}, 0);
    chk("rst_mems", {31'b0, mem_s}, 1);
    chk("rst_busen", {31'b0, bus_en}, 0);
    chk("rst_busd", {16'b0, bus_data}, 0);
`ifdef STACK_SEQ_AFULL_EN
    chk("rst_afull", {31'b0, afull}, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    sp0 = sp;
    op_chk("push1", PUSH, 16'h1234, 3, 1'b0, 1, 1, 0);
    chk("push1_depth", 32'(depth), 1);
    chk("push1_empty", {31'b0, empty}, 0);
    chk("push1_busd", {16'b0, bus_data}, 32'h1234);
    op_chk("pop1", POP, 16'h0, 3, 1'b0, 0, 0, 1);
    chk("pop1_data", {16'b0, dout}, 32'h1234);
    chk("pop1_depth", 32'(depth), 0);

    op_chk("pushA", PUSH, 16'hAAAA, 3, 1'b0, 1, 1, 0);
    op_chk("push5", PUSH, 16'h5555, 3, 1'b0, 1, 1, 0);
    op_chk("pop5", POP, 16'h0, 3, 1'b0, 0, 0, 1);
    chk("pop5_data", {16'b0, dout}, 32'h5555);
    chk("pop5_depth", 32'(depth), 1);
    op_chk("popA", POP, 16'h0, 3, 1'b0, 0, 0, 1);
    chk("popA_data", {16'b0, dout}, 32'hAAAA);
    chk("popA_depth", 32'(depth), 0);
    chk("popA_empty", {31'b0, empty}, 1);
    chk("sp_home", {24'b0, sp}, {24'b0, sp0});

    op_chk("push11", PUSH, 16'h1111, 3, 1'b0, 1, 1, 0);
    op_chk("pushBE", PUSH, 16'hBEEF, 3, 1'b0, 1, 1, 0);
    sp0 = sp;
    op_chk("peek", PEEK, 16'h0, 4, 1'b0, 0, 1, 1);
    chk("peek_data", {16'b0, dout}, 32'hBEEF);
    chk("peek_depth", 32'(depth), 2);
    chk("peek_sp", {24'b0, sp}, {24'b0, sp0});
    op_chk("popBE", POP, 16'h0, 3, 1'b0, 0, 0, 1);
    chk("popBE_data", {16'b0, dout}, 32'hBEEF);
    op_chk("pop11", POP, 16'h0, 3, 1'b0, 0, 0, 1);
    chk("pop11_data", {16'b0, dout}, 32'h1111);

    for (int k = 1; k <= D; k++) begin
      run_op(PUSH, 16'hC000 + 16'(k), 1'b0, lat, e, nw, ni, nd, nr);
      chk($sformatf("fill%0d_lat", k), lat, 3);
      chk($sformatf("fill%0d_depth", k), 32'(depth), k);
      chk($sformatf("fill%0d_full", k), {31'b0, full}, (k == D) ? 1 : 0);
`ifdef STACK_SEQ_AFULL_EN
      chk($sformatf("fill%0d_afull", k), {31'b0, afull},
          (k >= D - M) ? 1 : 0);
`endif
    end
    op_chk("ovf", PUSH, 16'hDEAD, 1, 1'b1, 0, 0, 0);
    chk("ovf_depth", 32'(depth), D);
    chk("ovf_full", {31'b0, full}, 1);

    for (int k = D; k >= 1; k--) begin
      run_op(POP, 16'h0, 1'b0, lat, e, nw, ni, nd, nr);
      chk($sformatf("drain%0d_data", k), {16'b0, dout}, 32'hC000 + k);
      chk($sformatf("drain%0d_depth", k), 32'(depth), k - 1);
`ifdef STACK_SEQ_AFULL_EN
      chk($sformatf("drain%0d_afull", k), {31'b0, afull},
          (k - 1 >= D - M) ? 1 : 0);
`endif
    end
    op_chk("udf", POP, 16'h0, 1, 1'b1, 0, 0, 0);
    chk("udf_data", {16'b0, dout}, 32'hC001);
    chk("udf_depth", 32'(depth), 0);
    op_chk("udfpk", PEEK, 16'h0, 1, 1'b1, 0, 0, 0);

    run_op(PUSH, 16'h4242, 1'b1, lat, e, nw, ni, nd, nr);
    chk("hold_lat", lat, 3);
    chk("hold_rdy", nr, 0);
    chk("hold_wr", nw, 1);
    repeat (3) @(negedge clk);
    chk("hold_depth", 32'(depth), 1);
    chk("hold_done", {31'b0, done}, 0);

    @(negedge clk);
    req = 1'b1; opr = PUSH; din = 16'h9999;
    @(posedge clk);
    #1;
    chk("mid_busen", {31'b0, bus_en}, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_busen0", {31'b0, bus_en}, 0);
    chk("mid_memw0", {31'b0, mem_w}, 0);
    chk("mid_spc0", {29'b0, sp_ctrl}, 0);
    chk("mid_ready", {31'b0, ready}, 1);
    chk("mid_depth", 32'(depth), 0);
    req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    op_chk("post_push", PUSH, 16'h7777, 3, 1'b0, 1, 1, 0);
    op_chk("post_pop", POP, 16'h0, 3, 1'b0, 0, 0, 1);
    chk("post_data", {16'b0, dout}, 32'h7777);

    chk("bus_conflict", {31'b0, conflict}, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/stack_seq.md
Name: stack_seq

Overview:
- Sequencer for the hardware stack datapath: the stack-pointer register (3-bit control), the stack memory (write, bus-select), and the shared 16-bit bus.
- Accepts one push/pop/peek request at a time over a ready/done handshake.
- Generates the per-cycle control strobes and tracks depth, full and empty.
- Owns the bus whenever it is not idle.

Parameters:
DEPTH, 256, maximum number of entries (1..65535)
DEPTH_W, 16, width of the depth counter; must satisfy 2^DEPTH_W > DEPTH
AFULL_MARGIN, 4, almost-full threshold margin (used only with the optional feature)

Ports:
i_clock  in  1  system clock, rising edge
i_reset_n  in  1  asynchronous active-low reset
i_req  in  1  request valid; sampled only while o_ready=1
i_op  in  [0:1]  00 nop, 01 push, 10 pop, 11 peek
i_data  in  [0:15]  push data, captured on accept
o_ready  out  1  sequencer idle, can accept
o_done  out  1  one-cycle completion pulse
o_err  out  1  one-cycle pulse with o_done: overflow or underflow, op discarded
o_data  out  [0:15]  pop/peek result, held until next pop/peek completes
o_depth  out  DEPTH_W  current entry count
o_full  out  1  o_depth == DEPTH
o_empty  out  1  o_depth == 0
o_sp_ctrl  out  [0:2]  to stack pointer: [0] drive SP onto bus; [1:2] 01 = increment, 10 = decrement, 00/11 = hold
o_mem_w  out  1  stack memory write enable at current SP
o_mem_s  out  1  0 = memory drives bus (read), 1 = memory tri-stated
o_bus_en  out  1  sequencer drives o_bus_data onto bus
o_bus_data  out  [0:15]  registered push data
i_bus  in  [0:15]  bus value, captured in read states

Behaviour:
- Reset (async, i_reset_n=0):
  - state IDLE; o_ready=1; o_done=0; o_err=0.
  - o_data=0, o_depth=0, o_empty=1, o_full=0.
  - o_sp_ctrl=000, o_mem_w=0, o_mem_s=1, o_bus_en=0, o_bus_data=0.
  - Reset mid-operation aborts the sequence immediately. No further strobes. Depth returns to 0; the SP register is not reset by this block.
- All control outputs are registered (decoded from state). Bus is never multiply driven:
  - o_bus_en=1 only in PUSH_WR.
  - o_mem_s=0 only in the RD states.
  - o_sp_ctrl[0] is always 0.
- SP convention: SP points to the next free slot. Push writes then increments; pop decrements then reads.
- FSM:
  - IDLE: o_ready=1.
    - Accept on i_req=1 and i_op!=00; nop is ignored.
    - On accept, latch op; latch i_data into o_bus_data for push.
    - Push when full, or pop/peek when empty → ERR; otherwise push → PUSH_WR, pop → POP_DEC, peek → PK_DEC.
  - PUSH_WR: o_bus_en=1, o_mem_w=1 → PUSH_INC.
  - PUSH_INC: o_sp_ctrl=001; depth+1 → DONE.
  - POP_DEC: o_sp_ctrl=010 → POP_RD.
  - POP_RD: o_mem_s=0; o_data<=i_bus at cycle end; depth-1 → DONE.
  - PK_DEC: o_sp_ctrl=010 → PK_RD.
  - PK_RD: o_mem_s=0; o_data<=i_bus → PK_INC.
  - PK_INC: o_sp_ctrl=001; depth unchanged → DONE.
  - ERR: o_done=1, o_err=1; no datapath strobes; depth and o_data unchanged → IDLE.
  - DONE: o_done=1 → IDLE.
- Latency, accept edge to o_done high: push 3 cycles, pop 3, peek 4, error 1. Back-to-back throughput is one op per latency+1 cycles.
- o_ready=0 in every state except IDLE; i_req is ignored while busy. The requester must hold i_req/i_op/i_data stable until accepted.
- o_full and o_empty are combinational decodes of the registered depth; they update the cycle after PUSH_INC/POP_RD.
- Depth never wraps: overflow and underflow are blocked by the ERR path.

Optional Feature:
STACK_SEQ_AFULL_EN
- Defined: adds output o_afull (1 bit), registered, =1 when o_depth >= DEPTH-AFULL_MARGIN. Reset value 0.
- Not defined: port absent; AFULL_MARGIN unused; all other behaviour identical.

Test Plan:
- Reset then push 0x1234 → 3 cycles later o_done=1, o_err=0, o_depth=1, o_empty=0. Exactly one cycle each of o_mem_w with o_bus_en=1, and o_sp_ctrl=001.
- Push 0xAAAA, push 0x5555, pop → o_data=0x5555, depth 1. Pop → o_data=0xAAAA, depth 0, o_empty=1. Bench memory/SP model checks SP returns to start.
- Peek with depth 2, top 0xBEEF → o_done after 4 cycles, o_data=0xBEEF, depth stays 2, net SP change 0.
- DEPTH=4: 4 pushes → o_full=1. 5th push → o_done+o_err in 1 cycle, no strobes, depth 4. Pop on empty → o_err, o_data unchanged.
- Assert i_reset_n=0 during PUSH_WR → all strobes deassert immediately, o_ready=1, depth 0. Also check i_req held during busy is not double-accepted.
- With STACK_SEQ_AFULL_EN, DEPTH=8, AFULL_MARGIN=2: o_afull rises after the 6th push and falls after the next pop.
